// File: rtl/sram_array_ctrl_if.sv
// Request, response and RW0 macro signal bundle for sram_array_ctrl.
// master: requester plus array side; slave: the controller.
interface sram_array_ctrl_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned WIDTH  = 22
);
    logic              r_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] r_addr;
    logic              w_valid;
    logic [ADDR_W-1:0] w_addr;
    logic [WIDTH-1:0]  w_data;
    logic              w_mask;
    logic              resp_valid;
    logic [WIDTH-1:0]  resp_data;
    logic              init_done;
    logic [ADDR_W-1:0] RW0_addr;
    logic              RW0_en;
    logic              RW0_wmode;
    logic              RW0_wmask;
    logic [WIDTH-1:0]  RW0_wdata;
    logic [WIDTH-1:0]  RW0_rdata;

    modport master (
        output r_valid, r_addr, w_valid, w_addr, w_data, w_mask, RW0_rdata,
        input  r_ready, resp_valid, resp_data, init_done,
        input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
    );

    modport slave (
        input  r_valid, r_addr, w_valid, w_addr, w_data, w_mask, RW0_rdata,
        output r_ready, resp_valid, resp_data, init_done,
        output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
    );
endinterface

// File: rtl/sram_array_ctrl.sv
// Single-port SRAM controller: zero-fill sweep after reset, then write-priority arbitration.
// Optional `SRAM_ARRAY_CTRL_HOLD_READ_EN keeps resp_data at the last read result between reads.
module sram_array_ctrl #(
    parameter int unsigned SETS         = 128,
    parameter int unsigned ADDR_W       = 7,
    parameter int unsigned WIDTH        = 22,
    parameter bit          SHOULD_RESET = 1'b1
) (
    input logic              clock,
    input logic              reset_n,
    sram_array_ctrl_if.slave bus
);
    typedef enum logic [0:0] {StInit, StIdle} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [ADDR_W-1:0] r_init_cnt;
    logic [ADDR_W-1:0] w_init_cnt_d;
    logic              r_init_done;
    logic              w_init_done_d;
    logic              r_resp_valid;

    logic              w_sweep_last;
    logic              w_r_ready;
    logic              w_rd_fire;
    logic              w_rw0_en;
    logic              w_rw0_wmode;
    logic              w_rw0_wmask;
    logic [ADDR_W-1:0] w_rw0_addr;
    logic [WIDTH-1:0]  w_rw0_wdata;

    // Exact compare: counter wraps to 0 on the same edge the sweep ends.
    assign w_sweep_last = (r_init_cnt == ADDR_W'(SETS - 1));
    assign w_rd_fire    = bus.r_valid && w_r_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= SHOULD_RESET ? StInit : StIdle;
            r_init_cnt   <= '0;
            r_init_done  <= !SHOULD_RESET;
            r_resp_valid <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_init_cnt   <= w_init_cnt_d;
            r_init_done  <= w_init_done_d;
            r_resp_valid <= w_rd_fire;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_init_cnt_d  = r_init_cnt;
        w_init_done_d = r_init_done;
        w_r_ready     = 1'b0;
        w_rw0_en      = 1'b0;
        w_rw0_wmode   = 1'b0;
        w_rw0_wmask   = 1'b0;
        w_rw0_addr    = '0;
        w_rw0_wdata   = '0;
        // Macro stays quiet and no request is accepted while reset is held.
        if (reset_n) begin
            unique case (r_state)
                StInit: begin
                    w_rw0_en     = 1'b1;
                    w_rw0_wmode  = 1'b1;
                    w_rw0_wmask  = 1'b1;
                    w_rw0_addr   = r_init_cnt;
                    w_init_cnt_d = r_init_cnt + ADDR_W'(1);
                    if (w_sweep_last) begin
                        w_state_d     = StIdle;
                        w_init_done_d = 1'b1;
                    end
                end
                StIdle: begin
                    w_r_ready = r_init_done && !bus.w_valid;
                    if (bus.w_valid) begin
                        w_rw0_en    = 1'b1;
                        w_rw0_wmode = 1'b1;
                        w_rw0_wmask = bus.w_mask;
                        w_rw0_addr  = bus.w_addr;
                        w_rw0_wdata = bus.w_data;
                    end else if (bus.r_valid) begin
                        w_rw0_en   = 1'b1;
                        w_rw0_addr = bus.r_addr;
                    end
                end
                default: w_state_d = StInit;
            endcase
        end
    end

    assign bus.r_ready    = w_r_ready;
    assign bus.init_done  = r_init_done;
    assign bus.resp_valid = r_resp_valid;
    assign bus.RW0_en     = w_rw0_en;
    assign bus.RW0_wmode  = w_rw0_wmode;
    assign bus.RW0_wmask  = w_rw0_wmask;
    assign bus.RW0_addr   = w_rw0_addr;
    assign bus.RW0_wdata  = w_rw0_wdata;

`ifdef SRAM_ARRAY_CTRL_HOLD_READ_EN
    logic [WIDTH-1:0] r_hold;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_hold <= '0;
        end else if (r_resp_valid) begin
            r_hold <= bus.RW0_rdata;
        end
    end

    assign bus.resp_data = r_resp_valid ? bus.RW0_rdata : r_hold;
`else
    assign bus.resp_data = bus.RW0_rdata;
`endif
endmodule

// File: tb/tb_sram_array_ctrl.sv
// Self-checking bench for sram_array_ctrl: behavioural macro plus a reference memory
// model; directed scenarios followed by randomized read/write traffic.
module tb_sram_array_ctrl;
    localparam int unsigned SETS   = 128;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned WIDTH  = 22;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    logic [WIDTH-1:0] ref_mem [SETS];
`ifdef SRAM_ARRAY_CTRL_HOLD_READ_EN
    logic [WIDTH-1:0] last_resp;
`endif

    always #5 clock = ~clock;

    sram_array_ctrl_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) bus ();

    sram_array_ctrl #(
        .SETS        (SETS),
        .ADDR_W      (ADDR_W),
        .WIDTH       (WIDTH),
        .SHOULD_RESET(1'b1)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    // Array macro: starts full of garbage, returns garbage whenever no read was issued.
    logic [WIDTH-1:0] macro_mem [SETS];
    bit               seeded = 1'b0;

    always @(posedge clock) begin
        if (!seeded) begin
            for (int i = 0; i < SETS; i++) macro_mem[i] <= WIDTH'($urandom);
            seeded        <= 1'b1;
            bus.RW0_rdata <= WIDTH'($urandom);
        end else if (bus.RW0_en && !bus.RW0_wmode) begin
            bus.RW0_rdata <= macro_mem[bus.RW0_addr];
        end else begin
            if (bus.RW0_en && bus.RW0_wmask) macro_mem[bus.RW0_addr] <= bus.RW0_wdata;
            bus.RW0_rdata <= WIDTH'($urandom);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        bus.r_valid = 1'b0;
        bus.r_addr  = '0;
        bus.w_valid = 1'b0;
        bus.w_addr  = '0;
        bus.w_data  = '0;
        bus.w_mask  = 1'b0;
    endtask

    function automatic logic [31:0] rw0_vec();
        return {bus.RW0_en, bus.RW0_wmode, bus.RW0_wmask, bus.RW0_wdata, bus.RW0_addr};
    endfunction

    task automatic test_reset();
        logic [34:0] obs;
        logic [34:0] exp;
        idle_inputs();
        bus.r_valid = 1'b1;
        bus.r_addr  = 7'd5;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < SETS; c++) begin
            settle();
            obs = {rw0_vec(), bus.r_ready, bus.init_done, bus.resp_valid};
            exp = {3'b111, 22'h0, ADDR_W'(c), 3'b000};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL sweep cycle %0d: got %h expected %h", c, obs, exp);
            end
            tick();
        end
        settle();
        obs = {rw0_vec(), bus.r_ready, bus.init_done, bus.resp_valid};
        exp = {3'b100, 22'h0, 7'd5, 3'b110};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL first idle read: got %h expected %h", obs, exp);
        end
        tick();
        bus.r_valid = 1'b0;
        settle();
        checks++;
        if ({bus.resp_valid, bus.resp_data} !== {1'b1, 22'h0}) begin
            errors++;
            $display("FAIL post-sweep resp: got %b/%h expected 1/000000",
                     bus.resp_valid, bus.resp_data);
        end
        for (int i = 0; i < SETS; i++) ref_mem[i] = '0;
        tick();
    endtask

    task automatic test_write_read();
        idle_inputs();
        bus.w_valid = 1'b1;
        bus.w_addr  = 7'h12;
        bus.w_data  = 22'h2AAAAA;
        bus.w_mask  = 1'b1;
        settle();
        checks++;
        if ({rw0_vec(), bus.r_ready} !== {3'b111, 22'h2AAAAA, 7'h12, 1'b0}) begin
            errors++;
            $display("FAIL write cmd: got %h ready %b", rw0_vec(), bus.r_ready);
        end
        ref_mem[7'h12] = 22'h2AAAAA;
        tick();
        idle_inputs();
        bus.r_valid = 1'b1;
        bus.r_addr  = 7'h12;
        settle();
        checks++;
        if ({rw0_vec(), bus.r_ready} !== {3'b100, 22'h0, 7'h12, 1'b1}) begin
            errors++;
            $display("FAIL read cmd: got %h ready %b", rw0_vec(), bus.r_ready);
        end
        tick();
        idle_inputs();
        settle();
        checks++;
        if ({bus.resp_valid, bus.resp_data} !== {1'b1, 22'h2AAAAA}) begin
            errors++;
            $display("FAIL write-read resp: got %b/%h expected 1/2aaaaa",
                     bus.resp_valid, bus.resp_data);
        end
        tick();
    endtask

    task automatic test_collision();
        idle_inputs();
        bus.w_valid = 1'b1;
        bus.w_addr  = 7'd3;
        bus.w_data  = 22'h155555;
        bus.w_mask  = 1'b1;
        bus.r_valid = 1'b1;
        bus.r_addr  = 7'd3;
        settle();
        checks++;
        if ({bus.RW0_wmode, bus.r_ready, bus.RW0_addr} !== {1'b1, 1'b0, 7'd3}) begin
            errors++;
            $display("FAIL collision arb: wmode %b ready %b addr %h expected 1 0 03",
                     bus.RW0_wmode, bus.r_ready, bus.RW0_addr);
        end
        ref_mem[3] = 22'h155555;
        tick();
        bus.w_valid = 1'b0;
        settle();
        checks++;
        if ({bus.r_ready, bus.resp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL stalled read retry: ready %b resp_valid %b expected 1 0",
                     bus.r_ready, bus.resp_valid);
        end
        tick();
        idle_inputs();
        settle();
        checks++;
        if ({bus.resp_valid, bus.resp_data} !== {1'b1, 22'h155555}) begin
            errors++;
            $display("FAIL collision resp: got %b/%h expected 1/155555",
                     bus.resp_valid, bus.resp_data);
        end
        tick();
    endtask

    task automatic test_mask();
        idle_inputs();
        bus.w_valid = 1'b1;
        bus.w_addr  = 7'd7;
        bus.w_data  = 22'h3FFFFF;
        bus.w_mask  = 1'b0;
        settle();
        checks++;
        if (rw0_vec() !== {3'b110, 22'h3FFFFF, 7'd7}) begin
            errors++;
            $display("FAIL masked write cmd: got %h", rw0_vec());
        end
        tick();
        idle_inputs();
        bus.r_valid = 1'b1;
        bus.r_addr  = 7'd7;
        tick();
        idle_inputs();
        settle();
        checks++;
        if ({bus.resp_valid, bus.resp_data} !== {1'b1, 22'h0}) begin
            errors++;
            $display("FAIL masked write read: got %b/%h expected 1/000000",
                     bus.resp_valid, bus.resp_data);
        end
        tick();
    endtask

`ifdef SRAM_ARRAY_CTRL_HOLD_READ_EN
    task automatic test_hold();
        idle_inputs();
        bus.w_valid = 1'b1;
        bus.w_addr  = 7'd1;
        bus.w_data  = 22'h0ABCDE;
        bus.w_mask  = 1'b1;
        ref_mem[1]  = 22'h0ABCDE;
        tick();
        idle_inputs();
        bus.r_valid = 1'b1;
        bus.r_addr  = 7'd1;
        tick();
        idle_inputs();
        settle();
        checks++;
        if ({bus.resp_valid, bus.resp_data} !== {1'b1, 22'h0ABCDE}) begin
            errors++;
            $display("FAIL hold read: got %b/%h expected 1/0abcde",
                     bus.resp_valid, bus.resp_data);
        end
        tick();
        for (int c = 0; c < 7; c++) begin
            idle_inputs();
            if (c == 5) begin
                bus.w_valid = 1'b1;
                bus.w_addr  = 7'd1;
                bus.w_data  = 22'h000123;
                bus.w_mask  = 1'b1;
                ref_mem[1]  = 22'h000123;
            end
            settle();
            checks++;
            if ({bus.resp_valid, bus.resp_data} !== {1'b0, 22'h0ABCDE}) begin
                errors++;
                $display("FAIL hold cycle %0d: got %b/%h expected 0/0abcde",
                         c, bus.resp_valid, bus.resp_data);
            end
            tick();
        end
        idle_inputs();
        bus.r_valid = 1'b1;
        bus.r_addr  = 7'd1;
        tick();
        idle_inputs();
        settle();
        checks++;
        if ({bus.resp_valid, bus.resp_data} !== {1'b1, 22'h000123}) begin
            errors++;
            $display("FAIL hold reread: got %b/%h expected 1/000123",
                     bus.resp_valid, bus.resp_data);
        end
        last_resp = 22'h000123;
        tick();
    endtask
`endif

    task automatic test_random();
        bit               pend     = 1'b0;
        bit               exp_resp = 1'b0;
        logic [ADDR_W-1:0] pend_addr = '0;
        logic [WIDTH-1:0]  exp_data  = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle_inputs();
            bus.w_valid = ($urandom_range(0, 2) == 0);
            if (bus.w_valid) begin
                bus.w_addr = ADDR_W'($urandom_range(0, 15));
                bus.w_data = WIDTH'($urandom);
                bus.w_mask = ($urandom_range(0, 3) != 0);
            end
            if (!pend && ($urandom_range(0, 1) == 1)) begin
                pend      = 1'b1;
                pend_addr = ADDR_W'($urandom_range(0, 15));
            end
            bus.r_valid = pend;
            bus.r_addr  = pend ? pend_addr : ADDR_W'($urandom);
            settle();
            checks++;
            if (bus.resp_valid !== exp_resp || (exp_resp && bus.resp_data !== exp_data)) begin
                errors++;
                $display("FAIL random resp cyc %0d: got %b/%h expected %b/%h",
                         cyc, bus.resp_valid, bus.resp_data, exp_resp, exp_data);
            end
`ifdef SRAM_ARRAY_CTRL_HOLD_READ_EN
            if (!exp_resp) begin
                checks++;
                if (bus.resp_data !== last_resp) begin
                    errors++;
                    $display("FAIL random hold cyc %0d: got %h expected %h",
                             cyc, bus.resp_data, last_resp);
                end
            end else begin
                last_resp = exp_data;
            end
`endif
            checks++;
            if (bus.r_ready !== !bus.w_valid) begin
                errors++;
                $display("FAIL random ready cyc %0d: got %b expected %b",
                         cyc, bus.r_ready, !bus.w_valid);
            end
            exp_resp = 1'b0;
            if (bus.w_valid) begin
                if (bus.w_mask) ref_mem[bus.w_addr] = bus.w_data;
            end else if (pend) begin
                exp_resp = 1'b1;
                exp_data = ref_mem[pend_addr];
                pend     = 1'b0;
            end
            tick();
        end
        idle_inputs();
        settle();
        checks++;
        if (bus.resp_valid !== exp_resp || (exp_resp && bus.resp_data !== exp_data)) begin
            errors++;
            $display("FAIL random drain: got %b/%h expected %b/%h",
                     bus.resp_valid, bus.resp_data, exp_resp, exp_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        int n         = 0;
        bit seen_resp = 1'b0;
        idle_inputs();
        bus.r_valid = 1'b1;
        bus.r_addr  = 7'd9;
        reset_n = 1'b0;
        settle();
        checks++;
        if ({bus.r_ready, bus.RW0_en} !== 2'b00) begin
            errors++;
            $display("FAIL read under reset: ready %b en %b expected 0 0",
                     bus.r_ready, bus.RW0_en);
        end
        tick();
        reset_n     = 1'b1;
        bus.r_valid = 1'b0;
        for (int c = 0; c < 60; c++) tick();
        settle();
        checks++;
        if ({bus.RW0_addr, bus.init_done, bus.resp_valid} !== {7'd60, 2'b00}) begin
            errors++;
            $display("FAIL sweep cycle 60: addr %h done %b resp %b expected 3c 0 0",
                     bus.RW0_addr, bus.init_done, bus.resp_valid);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        settle();
        checks++;
        if ({bus.RW0_en, bus.RW0_wmode, bus.RW0_addr} !== {2'b11, 7'd0}) begin
            errors++;
            $display("FAIL sweep restart: en %b wmode %b addr %h expected 1 1 00",
                     bus.RW0_en, bus.RW0_wmode, bus.RW0_addr);
        end
        while (!bus.init_done && n < 400) begin
            if (bus.resp_valid) seen_resp = 1'b1;
            tick();
            settle();
            n++;
        end
        checks++;
        if (n != SETS) begin
            errors++;
            $display("FAIL restart sweep length: got %0d cycles expected %0d", n, SETS);
        end
        checks++;
        if (seen_resp) begin
            errors++;
            $display("FAIL restart sweep resp: got resp_valid pulse expected none");
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_read();
        test_collision();
        test_mask();
`ifdef SRAM_ARRAY_CTRL_HOLD_READ_EN
        test_hold();
`endif
        test_random();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
